// File: rtl/commit_trace_queue_pkg.sv
// commit_trace_queue_pkg
//   Shared field widths, packed commit-record width and trace-queue state
//   encodings for the commit trace queue.
//   Record layout (MSB..LSB): pc, dnpc, inst, wnum, wdata, exp, mret, halt, wen.
package commit_trace_queue_pkg;

  localparam int PC_WD      = 64;
  localparam int INST_WD    = 32;
  localparam int RF_ADDR_WD = 5;
  localparam int RF_DATA_WD = 64;

  localparam int CMT_REC_WD = 2 * PC_WD + INST_WD + RF_ADDR_WD + RF_DATA_WD + 4;

  localparam logic [1:0] CTQ_RUN    = 2'd0;
  localparam logic [1:0] CTQ_DRAIN  = 2'd1;
  localparam logic [1:0] CTQ_HALTED = 2'd2;

  // Packed record width for an arbitrary set of field widths.
  function automatic int cmt_rec_wd(input int pc_wd, input int inst_wd,
                                    input int addr_wd, input int data_wd);
    return 2 * pc_wd + inst_wd + addr_wd + data_wd + 4;
  endfunction

endpackage

// File: rtl/commit_fifo_mem.sv
// commit_fifo_mem
//   DEPTH x WD register array: one synchronous write port, one asynchronous
//   read port. Storage is deliberately not reset.
//   Ports:
//     clk    in  clock
//     we     in  write enable
//     waddr  in  write address
//     wdata  in  write data
//     raddr  in  read address
//     rdata  out read data (combinational)
module commit_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WD    = commit_trace_queue_pkg::CMT_REC_WD
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WD-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WD-1:0]            rdata
);

  logic [WD-1:0] mem_r [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/commit_trace_queue.sv
// commit_trace_queue
//   Captures retired-instruction records from writeback into a FIFO and
//   drains them one at a time (first-word fall-through) over a valid/ready
//   port. A stop request marks exactly one record with halt; once that record
//   is popped the queue seals in HALTED until reset.
//   Ports:
//     clk, reset                 clock, async active-high reset
//     ws_valid, stop             retire strobe, simulation stop request
//     wb_pc/dnpc/inst/exp/mret   retiring instruction fields
//     wb_rf_wen/wnum/wdata       regfile write of the retiring instruction
//     rec_valid, rec_ready       drain handshake
//     rec_*                      head record fields (0 while empty)
//     full, overflow             FIFO full, sticky drop flag
//     commit_cnt, drop_cnt       accepted / dropped commit counters
//     state                      0=RUN, 1=DRAIN, 2=HALTED
module commit_trace_queue #(
  parameter int DEPTH      = 8,
  parameter int PC_WD      = commit_trace_queue_pkg::PC_WD,
  parameter int INST_WD    = commit_trace_queue_pkg::INST_WD,
  parameter int RF_ADDR_WD = commit_trace_queue_pkg::RF_ADDR_WD,
  parameter int RF_DATA_WD = commit_trace_queue_pkg::RF_DATA_WD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ws_valid,
  input  logic                  stop,
  input  logic [PC_WD-1:0]      wb_pc,
  input  logic [PC_WD-1:0]      wb_dnpc,
  input  logic [INST_WD-1:0]    wb_inst,
  input  logic                  wb_exp,
  input  logic                  wb_mret,
  input  logic                  wb_rf_wen,
  input  logic [RF_ADDR_WD-1:0] wb_rf_wnum,
  input  logic [RF_DATA_WD-1:0] wb_rf_wdata,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [PC_WD-1:0]      rec_pc,
  output logic [PC_WD-1:0]      rec_dnpc,
  output logic [INST_WD-1:0]    rec_inst,
  output logic                  rec_exp,
  output logic                  rec_mret,
  output logic                  rec_halt,
  output logic                  rec_wen,
  output logic [RF_ADDR_WD-1:0] rec_wnum,
  output logic [RF_DATA_WD-1:0] rec_wdata,
  output logic                  full,
  output logic                  overflow,
  output logic [63:0]           commit_cnt,
  output logic [31:0]           drop_cnt,
  output logic [1:0]            state
);

  import commit_trace_queue_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = cmt_rec_wd(PC_WD, INST_WD, RF_ADDR_WD, RF_DATA_WD);

  // Bit offsets inside a packed record.
  localparam int O_WEN   = 0;
  localparam int O_HALT  = 1;
  localparam int O_MRET  = 2;
  localparam int O_EXP   = 3;
  localparam int O_WDATA = 4;
  localparam int O_WNUM  = O_WDATA + RF_DATA_WD;
  localparam int O_INST  = O_WNUM + RF_ADDR_WD;
  localparam int O_DNPC  = O_INST + INST_WD;
  localparam int O_PC    = O_DNPC + PC_WD;

  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [1:0]    state_r;
  logic          halt_pend_r;
  logic [RW-1:0] side_rec_r;
  logic          overflow_r;
  logic [63:0]   commit_cnt_r;
  logic [31:0]   drop_cnt_r;

  logic          empty_s;
  logic          full_s;
  logic          halted_s;
  logic          valid_s;
  logic          pop_s;
  logic          space_s;
  logic [RW-1:0] head_s;
  logic [RW-1:0] live_rec_s;
  logic [RW-1:0] live_halt_rec_s;
  logic [RW-1:0] marker_rec_s;

  logic          push_s;
  logic [RW-1:0] push_rec_s;
  logic          accept_s;
  logic          drop_s;
  logic          pend_set_s;
  logic          pend_clr_s;
  logic [1:0]    state_nxt_s;

  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  // Encoding 3 is unreachable; bit 1 covers both HALTED and 3.
  assign halted_s = state_r[1];
  assign valid_s  = !empty_s && !halted_s;
  assign pop_s    = valid_s && rec_ready;
  // A slot is available if not full, or the head leaves on this same edge.
  assign space_s  = !full_s || pop_s;

  // A write to x0 is architecturally invisible, so wen is cleared for wnum 0.
  assign live_rec_s = {wb_pc, wb_dnpc, wb_inst, wb_rf_wnum, wb_rf_wdata,
                       wb_exp, wb_mret, 1'b0, wb_rf_wen && (wb_rf_wnum != {RF_ADDR_WD{1'b0}})};
  assign live_halt_rec_s = {wb_pc, wb_dnpc, wb_inst, wb_rf_wnum, wb_rf_wdata,
                            wb_exp, wb_mret, 1'b1, wb_rf_wen && (wb_rf_wnum != {RF_ADDR_WD{1'b0}})};
  assign marker_rec_s = {wb_pc, wb_dnpc, wb_inst, {RF_ADDR_WD{1'b0}}, {RF_DATA_WD{1'b0}},
                         1'b0, 1'b0, 1'b1, 1'b0};

  commit_fifo_mem #(
    .DEPTH (DEPTH),
    .WD    (RW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (push_rec_s),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (head_s)
  );

  // Push / drop / halt-pending decisions and next state.
  always_comb begin
    push_s      = 1'b0;
    push_rec_s  = live_rec_s;
    accept_s    = 1'b0;
    drop_s      = 1'b0;
    pend_set_s  = 1'b0;
    pend_clr_s  = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      CTQ_RUN: begin
        if (stop) begin
          state_nxt_s = CTQ_DRAIN;
          accept_s    = ws_valid;
          push_rec_s  = ws_valid ? live_halt_rec_s : marker_rec_s;
          if (space_s) begin
            push_s = 1'b1;
          end else begin
            // No slot: park the halt record in the side register.
            pend_set_s = 1'b1;
          end
        end else if (ws_valid) begin
          if (space_s) begin
            push_s   = 1'b1;
            accept_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          push_s = 1'b0;
        end
      end
      CTQ_DRAIN: begin
        if (halt_pend_r && space_s) begin
          push_s     = 1'b1;
          push_rec_s = side_rec_r;
          pend_clr_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
        if (pop_s && head_s[O_HALT]) begin
          state_nxt_s = CTQ_HALTED;
        end else begin
          state_nxt_s = CTQ_DRAIN;
        end
      end
      default: begin
        state_nxt_s = CTQ_HALTED;
      end
    endcase
  end

  // Pointers, state, halt-pending side register and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      state_r      <= CTQ_RUN;
      halt_pend_r  <= 1'b0;
      side_rec_r   <= {RW{1'b0}};
      overflow_r   <= 1'b0;
      commit_cnt_r <= 64'd0;
      drop_cnt_r   <= 32'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      state_r <= state_nxt_s;
      if (pend_set_s) begin
        halt_pend_r <= 1'b1;
        side_rec_r  <= push_rec_s;
      end else if (pend_clr_s) begin
        halt_pend_r <= 1'b0;
      end
      if (accept_s) begin
        commit_cnt_r <= commit_cnt_r + 64'd1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        drop_cnt_r <= drop_cnt_r + 32'd1;
      end
    end
  end

  // Head record fields, forced to zero whenever no record is presented.
  always_comb begin
    rec_pc    = {PC_WD{1'b0}};
    rec_dnpc  = {PC_WD{1'b0}};
    rec_inst  = {INST_WD{1'b0}};
    rec_exp   = 1'b0;
    rec_mret  = 1'b0;
    rec_halt  = 1'b0;
    rec_wen   = 1'b0;
    rec_wnum  = {RF_ADDR_WD{1'b0}};
    rec_wdata = {RF_DATA_WD{1'b0}};
    if (valid_s) begin
      rec_pc    = head_s[O_PC +: PC_WD];
      rec_dnpc  = head_s[O_DNPC +: PC_WD];
      rec_inst  = head_s[O_INST +: INST_WD];
      rec_exp   = head_s[O_EXP];
      rec_mret  = head_s[O_MRET];
      rec_halt  = head_s[O_HALT];
      rec_wen   = head_s[O_WEN];
      rec_wnum  = head_s[O_WNUM +: RF_ADDR_WD];
      rec_wdata = head_s[O_WDATA +: RF_DATA_WD];
    end else begin
      rec_halt = 1'b0;
    end
  end

  assign rec_valid  = valid_s;
  assign full       = full_s;
  assign overflow   = overflow_r;
  assign commit_cnt = commit_cnt_r;
  assign drop_cnt   = drop_cnt_r;
  assign state      = state_r;

endmodule

// File: tb/tb_commit_trace_queue.sv
module tb_commit_trace_queue;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] dnpc;
    logic [31:0] inst;
    logic        exp;
    logic        mret;
    logic        halt;
    logic        wen;
    logic [4:0]  wnum;
    logic [63:0] wdata;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ws_valid = 1'b0;
  logic        stop = 1'b0;
  logic [63:0] wb_pc = 64'd0;
  logic [63:0] wb_dnpc = 64'd0;
  logic [31:0] wb_inst = 32'd0;
  logic        wb_exp = 1'b0;
  logic        wb_mret = 1'b0;
  logic        wb_rf_wen = 1'b0;
  logic [4:0]  wb_rf_wnum = 5'd0;
  logic [63:0] wb_rf_wdata = 64'd0;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic [63:0] rec_pc, rec_dnpc, rec_wdata;
  logic [31:0] rec_inst;
  logic        rec_exp, rec_mret, rec_halt, rec_wen;
  logic [4:0]  rec_wnum;
  logic        full, overflow;
  logic [63:0] commit_cnt;
  logic [31:0] drop_cnt;
  logic [1:0]  state;

  always #5 clk = ~clk;

  commit_trace_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .stop(stop),
    .wb_pc(wb_pc), .wb_dnpc(wb_dnpc), .wb_inst(wb_inst), .wb_exp(wb_exp),
    .wb_mret(wb_mret), .wb_rf_wen(wb_rf_wen), .wb_rf_wnum(wb_rf_wnum),
    .wb_rf_wdata(wb_rf_wdata), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_pc(rec_pc), .rec_dnpc(rec_dnpc), .rec_inst(rec_inst), .rec_exp(rec_exp),
    .rec_mret(rec_mret), .rec_halt(rec_halt), .rec_wen(rec_wen),
    .rec_wnum(rec_wnum), .rec_wdata(rec_wdata), .full(full), .overflow(overflow),
    .commit_cnt(commit_cnt), .drop_cnt(drop_cnt), .state(state)
  );

  int vectors = 0;
  int miscompares = 0;

  // scoreboard of records the sink should see, in order
  rec_t exp_q[$];
  // reference model: queue contents, state (0 run, 1 drain, 2 halted), counters
  rec_t        mq[$];
  int          m_state = 0;
  bit          m_pend = 1'b0;
  rec_t        m_side;
  bit          m_ovf = 1'b0;
  logic [63:0] m_commit = 64'd0;
  logic [31:0] m_drop = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic rec_t live_rec();
    rec_t r;
    r.pc = wb_pc; r.dnpc = wb_dnpc; r.inst = wb_inst;
    r.exp = wb_exp; r.mret = wb_mret; r.halt = 1'b0;
    r.wen = wb_rf_wen && (wb_rf_wnum != 5'd0);
    r.wnum = wb_rf_wnum; r.wdata = wb_rf_wdata;
    return r;
  endfunction

  function automatic rec_t marker_rec();
    rec_t r;
    r.pc = wb_pc; r.dnpc = wb_dnpc; r.inst = wb_inst;
    r.exp = 1'b0; r.mret = 1'b0; r.halt = 1'b1; r.wen = 1'b0;
    r.wnum = 5'd0; r.wdata = 64'd0;
    return r;
  endfunction

  task automatic model_push(input rec_t r);
    mq.push_back(r);
    exp_q.push_back(r);
  endtask

  // What the next clock edge should do, given the inputs now applied.
  task automatic model_step();
    rec_t r, popped;
    bit   valid, pop, space;
    int   nxt;
    valid = (mq.size() > 0) && (m_state != 2);
    pop   = valid && rec_ready;
    space = (mq.size() < DEPTH) || pop;
    nxt   = m_state;
    if (pop) begin
      popped = mq.pop_front();
      if (m_state == 1 && popped.halt) nxt = 2;
    end
    if (m_state == 0) begin
      if (stop) begin
        nxt = 1;
        if (ws_valid) begin
          r = live_rec(); r.halt = 1'b1; m_commit = m_commit + 64'd1;
        end else begin
          r = marker_rec();
        end
        if (space) model_push(r);
        else begin m_pend = 1'b1; m_side = r; end
      end else if (ws_valid) begin
        if (space) begin model_push(live_rec()); m_commit = m_commit + 64'd1; end
        else begin m_drop = m_drop + 32'd1; m_ovf = 1'b1; end
      end
    end else if (m_state == 1) begin
      if (m_pend && space) begin model_push(m_side); m_pend = 1'b0; end
    end
    m_state = nxt;
  endtask

  task automatic rand_fields();
    wb_pc       = {$urandom, $urandom};
    wb_dnpc     = {$urandom, $urandom};
    wb_inst     = $urandom;
    wb_exp      = 1'($urandom_range(0, 1));
    wb_mret     = 1'($urandom_range(0, 1));
    wb_rf_wen   = 1'($urandom_range(0, 1));
    wb_rf_wnum  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    wb_rf_wdata = {$urandom, $urandom};
  endtask

  // Apply one cycle: inputs are already set; advance model and DUT, then check.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("rec_valid", {63'd0, rec_valid}, {63'd0, (mq.size() > 0) && (m_state != 2)});
    chk("full", {63'd0, full}, {63'd0, mq.size() == DEPTH});
    chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    chk("commit_cnt", commit_cnt, m_commit);
    chk("drop_cnt", {32'd0, drop_cnt}, {32'd0, m_drop});
    chk("state", {62'd0, state}, 64'(m_state));
  endtask

  task automatic drive(input bit ws, input bit st, input bit rdy);
    rand_fields();
    ws_valid = ws; stop = st; rec_ready = rdy;
    step();
  endtask

  task automatic do_reset();
    ws_valid = 1'b0; stop = 1'b0; rec_ready = 1'b0;
    reset = 1'b1;
    mq.delete(); exp_q.delete();
    m_state = 0; m_pend = 1'b0; m_ovf = 1'b0; m_commit = 64'd0; m_drop = 32'd0;
    #1;
    chk("rst_rec_valid", {63'd0, rec_valid}, 64'd0);
    chk("rst_state", {62'd0, state}, 64'd0);
    chk("rst_commit_cnt", commit_cnt, 64'd0);
    chk("rst_drop_cnt", {32'd0, drop_cnt}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head record is checked against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (rec_valid && rec_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_record", rec_pc, 64'd0);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          chk("rec_pc", rec_pc, e.pc);
          chk("rec_dnpc", rec_dnpc, e.dnpc);
          chk("rec_inst", {32'd0, rec_inst}, {32'd0, e.inst});
          chk("rec_flags", {60'd0, rec_exp, rec_mret, rec_halt, rec_wen},
              {60'd0, e.exp, e.mret, e.halt, e.wen});
          chk("rec_wnum", {59'd0, rec_wnum}, {59'd0, e.wnum});
          chk("rec_wdata", rec_wdata, e.wdata);
        end
      end else if (!rec_valid) begin
        chk("idle_zero", rec_pc | rec_dnpc | rec_wdata | {32'd0, rec_inst} |
            {54'd0, rec_wnum, rec_exp, rec_mret, rec_halt, rec_wen}, 64'd0);
      end
    end
  end

  initial begin
    int pops;
    int was_valid;

    // 1: single commit, latency 1
    do_reset();
    wb_pc = 64'h8000_0000; wb_dnpc = 64'h8000_0004; wb_inst = 32'h0010_0093;
    wb_exp = 1'b0; wb_mret = 1'b0; wb_rf_wen = 1'b1; wb_rf_wnum = 5'd1; wb_rf_wdata = 64'd1;
    ws_valid = 1'b1; stop = 1'b0; rec_ready = 1'b0;
    step();
    chk("t1_rec_valid", {63'd0, rec_valid}, 64'd1);
    chk("t1_rec_pc", rec_pc, 64'h8000_0000);
    chk("t1_rec_wen", {63'd0, rec_wen}, 64'd1);
    chk("t1_commit_cnt", commit_cnt, 64'd1);

    // 2: fill, overflow, full with simultaneous pop
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0);
    chk("t2_full", {63'd0, full}, 64'd1);
    drive(1'b1, 1'b0, 1'b0);
    chk("t2_overflow", {63'd0, overflow}, 64'd1);
    chk("t2_drop_cnt", {32'd0, drop_cnt}, 64'd1);
    chk("t2_commit_cnt8", commit_cnt, 64'd8);
    drive(1'b1, 1'b0, 1'b1);
    chk("t2_drop_cnt_hold", {32'd0, drop_cnt}, 64'd1);
    chk("t2_commit_cnt9", commit_cnt, 64'd9);

    // 3: write to x0 never reports wen
    do_reset();
    rand_fields();
    wb_rf_wen = 1'b1; wb_rf_wnum = 5'd0;
    ws_valid = 1'b1; stop = 1'b0; rec_ready = 1'b0;
    step();
    chk("t3_rec_wen", {63'd0, rec_wen}, 64'd0);

    // 4: stop with a live commit, then halt
    rand_fields();
    wb_pc = 64'h8000_0010;
    ws_valid = 1'b1; stop = 1'b1; rec_ready = 1'b1;
    step();
    chk("t4_rec_halt", {63'd0, rec_halt}, 64'd1);
    chk("t4_rec_pc", rec_pc, 64'h8000_0010);
    drive(1'b0, 1'b0, 1'b1);
    chk("t4_state", {62'd0, state}, 64'd2);
    chk("t4_rec_valid", {63'd0, rec_valid}, 64'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1);
    chk("t4_commit_cnt", commit_cnt, 64'd2);

    // 5: stop while full parks a marker, released by the first pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("t5_state_drain", {62'd0, state}, 64'd1);
    chk("t5_full", {63'd0, full}, 64'd1);
    pops = 0;
    for (int i = 0; i < 20 && state != 2'd2; i++) begin
      was_valid = rec_valid;
      drive(1'b1, 1'b1, 1'b1);
      if (was_valid != 0) pops++;
    end
    chk("t5_halted", {62'd0, state}, 64'd2);
    chk("t5_pops", 64'(pops), 64'd9);

    // 6: reset in the middle of a drain
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("t6_state_drain", {62'd0, state}, 64'd1);
    do_reset();

    // randomized segments with varying sink pressure
    for (int seg = 0; seg < 8; seg++) begin
      int rdy_pct;
      do_reset();
      rdy_pct = (seg % 4) * 30;
      for (int c = 0; c < 200 && m_state != 2; c++) begin
        drive($urandom_range(0, 99) < 70,
              (c > 20) && ($urandom_range(0, 99) < 3),
              $urandom_range(0, 99) < rdy_pct);
      end
      // finish the segment with a stop and a full drain
      for (int c = 0; c < 40 && m_state != 2; c++) drive(1'b1, 1'b1, 1'b1);
      chk("seg_halted", {62'd0, state}, 64'd2);
      chk("seg_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
